line_pattern_loader: RTL and testbench

LINE_PATTERN_LOADER -- requirements
Module: line_pattern_loader

---
 rtl/line_pattern_loader_if.sv | 12 +
 rtl/line_pattern_loader.sv | 126 ++++++++++++
 tb/tb_line_pattern_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/line_pattern_loader_if.sv
// Write-side bus from line_pattern_loader to the line FIFO.
// master drives pixel data and write request, slave returns the full flag.
interface line_pattern_loader_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] oFIFO_DATA;
  logic              oFIFO_WREQ;
  logic              iFIFO_FULL;

  modport master (output oFIFO_DATA, output oFIFO_WREQ, input iFIFO_FULL);
  modport slave  (input oFIFO_DATA, input oFIFO_WREQ, output iFIFO_FULL);
endinterface

// File: rtl/line_pattern_loader.sv
// Generates one line of a test pattern into the VGA line FIFO per load kick.
// Optional macro LINE_PATTERN_INVERT_EN adds iINVERT to complement the pattern.
module line_pattern_loader #(
  parameter int DATA_W      = 8,
  parameter int LINE_PIXELS = 1280,
  parameter int LINE_W      = 13,
  parameter int CNT_W       = 11
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLOAD_REQ,
  input  logic [LINE_W-1:0] iLOAD_VLINE,
  input  logic [1:0]        iMODE,
  input  logic [LINE_W-1:0] iBAND_START,
  input  logic [LINE_W-1:0] iBAND_LEN,
`ifdef LINE_PATTERN_INVERT_EN
  input  logic              iINVERT,
`endif
  line_pattern_loader_if.master fifo,
  output logic              oBUSY,
  output logic              oLINE_DONE,
  output logic              oOVERRUN
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_PIXELS - 1);

  state_t            state, state_nxt;
  logic              load_req_p1;
  logic              req_primed;
  logic              kick;
  logic              wreq;
  logic              last_pix;
  logic [CNT_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] vline_lat, start_lat, len_lat;
  logic [1:0]        mode_lat;
  logic              invert_lat;
  logic [DATA_W-1:0] pix;

  // Band end is formed one bit wider so START+LEN never wraps back to zero.
  function automatic logic in_band(input logic [LINE_W:0] x,
                                   input logic [LINE_W:0] start,
                                   input logic [LINE_W:0] len);
    logic [LINE_W:0] band_end;
    band_end = start + len;
    return (x >= start) && (x < band_end);
  endfunction

  // req_primed masks the first cycle after reset so a held request is not a kick
  assign kick     = iLOAD_REQ && !load_req_p1 && req_primed;
  assign last_pix = (pix_cnt == LAST_PIX);

  always_comb begin
    state_nxt = state;
    wreq      = 1'b0;
    oBUSY     = 1'b0;
    case (state)
      IDLE:  if (kick) state_nxt = ARMED;
      ARMED: begin
        oBUSY = 1'b1;
        if (!iLOAD_REQ) state_nxt = LOAD;
      end
      LOAD: begin
        oBUSY = 1'b1;
        wreq  = !fifo.iFIFO_FULL;
        if (wreq && last_pix) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      load_req_p1 <= 1'b0;
      req_primed  <= 1'b0;
      pix_cnt     <= '0;
      vline_lat   <= '0;
      start_lat   <= '0;
      len_lat     <= '0;
      mode_lat    <= '0;
      invert_lat  <= 1'b0;
      oLINE_DONE  <= 1'b0;
      oOVERRUN    <= 1'b0;
    end else begin
      state       <= state_nxt;
      load_req_p1 <= iLOAD_REQ;
      req_primed  <= 1'b1;
      oLINE_DONE  <= (state == LOAD) && wreq && last_pix;
      if (kick && state != IDLE) oOVERRUN <= 1'b1;
      if (kick && state == IDLE) begin
        vline_lat <= iLOAD_VLINE;
        start_lat <= iBAND_START;
        len_lat   <= iBAND_LEN;
        mode_lat  <= iMODE;
`ifdef LINE_PATTERN_INVERT_EN
        invert_lat <= iINVERT;
`else
        invert_lat <= 1'b0;
`endif
      end
      if (state == ARMED) pix_cnt <= '0;
      else if (wreq)      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_comb begin
    pix = '0;
    case (mode_lat)
      2'd0:    pix = {DATA_W{in_band({1'b0, vline_lat}, {1'b0, start_lat}, {1'b0, len_lat})}};
      2'd1:    pix = {DATA_W{in_band((LINE_W+1)'(pix_cnt), {1'b0, start_lat}, {1'b0, len_lat})}};
      2'd2:    pix = {DATA_W{vline_lat[5] ^ pix_cnt[5]}};
      default: pix = DATA_W'(pix_cnt);
    endcase
    if (invert_lat) pix = ~pix;
  end

  assign fifo.oFIFO_DATA = pix;
  assign fifo.oFIFO_WREQ = wreq;

endmodule

// File: tb/tb_line_pattern_loader.sv
// Scoreboard bench for line_pattern_loader: expected pixels are queued at each
// kick and popped by a monitor on every accepted FIFO write.
`timescale 1ns/1ps
module tb_line_pattern_loader;
  localparam int DATA_W      = 8;
  localparam int LINE_PIXELS = 1280;
  localparam int LINE_W      = 13;
  localparam int CNT_W       = 11;

  logic              CLOCK_50     = 1'b0;
  logic              temp_reset_n = 1'b0;
  logic              load_req     = 1'b0;
  logic [LINE_W-1:0] load_vline   = '0;
  logic [LINE_W-1:0] band_start   = '0;
  logic [LINE_W-1:0] band_len     = '0;
  logic [1:0]        mode         = '0;
  logic              invert       = 1'b0;
  logic              rand_full    = 1'b0;
  logic              busy, line_done, overrun;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  logic [DATA_W-1:0] exp_q[$];

  line_pattern_loader_if #(.DATA_W(DATA_W)) fifo_if ();

  line_pattern_loader #(
    .DATA_W(DATA_W), .LINE_PIXELS(LINE_PIXELS), .LINE_W(LINE_W), .CNT_W(CNT_W)
  ) dut (
    .iCLK        (CLOCK_50),
    .iRST_N      (temp_reset_n),
    .iLOAD_REQ   (load_req),
    .iLOAD_VLINE (load_vline),
    .iMODE       (mode),
    .iBAND_START (band_start),
    .iBAND_LEN   (band_len),
`ifdef LINE_PATTERN_INVERT_EN
    .iINVERT     (invert),
`endif
    .fifo        (fifo_if),
    .oBUSY       (busy),
    .oLINE_DONE  (line_done),
    .oOVERRUN    (overrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_pix(input int m, input int v, input int s,
                                                  input int l, input int p, input logic inv);
    logic [DATA_W-1:0] r;
    case (m)
      0:       r = (v >= s && v < s + l) ? '1 : '0;
      1:       r = (p >= s && p < s + l) ? '1 : '0;
      2:       r = (((v / 32) % 2) != ((p / 32) % 2)) ? '1 : '0;
      default: r = DATA_W'(p % 256);
    endcase
    if (inv) r = ~r;
    return r;
  endfunction

  // Monitor: every accepted write pops one expected pixel
  always @(negedge CLOCK_50) begin
    if (temp_reset_n) begin
      if (line_done) done_cnt++;
      if (fifo_if.oFIFO_WREQ) begin
        wr_cnt++;
        chk("wr_while_full", fifo_if.iFIFO_FULL, 1'b0);
        if (exp_q.size() == 0) chk("unexpected_wr", fifo_if.oFIFO_WREQ, 1'b0);
        else                   chk("pixel", fifo_if.oFIFO_DATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    fifo_if.iFIFO_FULL = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1 fifo_if.iFIFO_FULL = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic kick_line(input int m, input int v, input int s, input int l, input int pulse);
    @(posedge CLOCK_50);
    #1;
    mode       = 2'(m);
    load_vline = LINE_W'(v);
    band_start = LINE_W'(s);
    band_len   = LINE_W'(l);
    load_req   = 1'b1;
    for (int p = 0; p < LINE_PIXELS; p++) exp_q.push_back(model_pix(m, v, s, l, p, invert));
    repeat (pulse) @(posedge CLOCK_50);
    #1 load_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20000 && done_cnt < target; i++) @(posedge CLOCK_50);
    repeat (3) @(negedge CLOCK_50);
    chk("done_count", done_cnt, target);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after_line", busy, 1'b0);
  endtask

  task automatic run_line(input int m, input int v, input int s, input int l, input int pulse);
    int target;
    int base;
    target = done_cnt + 1;
    base   = wr_cnt;
    kick_line(m, v, s, l, pulse);
    wait_done(target);
    chk("writes_per_line", wr_cnt - base, LINE_PIXELS);
  endtask

  initial begin
    int target;
    int base;

    // Reset state, with the request held high across release
    load_req = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_wreq", fifo_if.oFIFO_WREQ, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", line_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_data", fifo_if.oFIFO_DATA, 8'h00);
    temp_reset_n = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1 chk("held_req_no_kick", busy, 1'b0);
    load_req = 1'b0;
    repeat (3) @(posedge CLOCK_50);

    // Horizontal band edges
    run_line(0, 99, 100, 100, 3);
    run_line(0, 100, 100, 100, 3);
    run_line(0, 199, 100, 100, 3);
    run_line(0, 200, 100, 100, 3);

    // Vertical band crossing the line end, empty band, band end past LINE_W bits
    run_line(1, 0, 1270, 20, 2);
    run_line(0, 5, 5, 0, 1);
    run_line(0, 8191, 8190, 10, 1);

    // Checker
    run_line(2, 32, 0, 0, 1);

    // Gradient with random FIFO back-pressure
    rand_full = 1'b1;
    run_line(3, 7, 0, 0, 3);
    rand_full = 1'b0;

    // Second kick during LOAD
    target = done_cnt + 1;
    base   = wr_cnt;
    kick_line(0, 150, 100, 100, 2);
    for (int i = 0; i < 5000 && wr_cnt < base + 500; i++) @(posedge CLOCK_50);
    #1;
    chk("busy_in_load", busy, 1'b1);
    chk("overrun_before", overrun, 1'b0);
    mode       = 2'd1;
    load_vline = '0;
    load_req   = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1 load_req = 1'b0;
    chk("overrun_set", overrun, 1'b1);
    wait_done(target);
    chk("overrun_writes", wr_cnt - base, LINE_PIXELS);
    chk("overrun_sticky", overrun, 1'b1);

    // Reset in the middle of a line
    target = done_cnt;
    base   = wr_cnt;
    kick_line(3, 0, 0, 0, 1);
    for (int i = 0; i < 5000 && wr_cnt < base + 700; i++) @(posedge CLOCK_50);
    #1;
    temp_reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_wreq", fifo_if.oFIFO_WREQ, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_overrun", overrun, 1'b0);
    repeat (2) @(posedge CLOCK_50);
    #1 temp_reset_n = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    chk("abort_no_done", done_cnt, target);
    run_line(3, 0, 0, 0, 2);

`ifdef LINE_PATTERN_INVERT_EN
    invert = 1'b1;
    run_line(2, 0, 0, 0, 1);
    invert = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
